mem_access_stage: RTL and testbench

- MEM pipeline stage; consumes the EX/MEM pipeline register outputs and feeds the MEM/WB register.
- Non-memory ops pass through combinationally with zero stall.
- Loads and stores run a data-bus req/ack transaction through a small FSM. The stage asserts stallreq to freeze upstream stages until the access completes, hits a timeout, or is rejected as misaligned.

---
 rtl/mem_access_stage_pkg.sv | 38 +++
 rtl/mem_lane_align.sv | 71 +++++++
 rtl/mem_access_stage.sv | 134 +++++++++++++
 tb/tb_mem_access_stage.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared constants, aluop codes and FSM encoding for the MEM stage and its lane helper.
package mem_access_stage_pkg;

  localparam logic        RST_ENABLE    = 1'b1;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam logic [4:0]  NOP_REG_ADDR  = 5'b00000;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;

  localparam int BUS_DATA_W = 32;
  localparam int BUS_ADDR_W = 32;
  localparam int BUS_SEL_W  = 4;

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_load(input logic [7:0] op);
    return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
           (op == EXE_LHU_OP) || (op == EXE_LW_OP);
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane steering: lane enables, store replication, load extraction, alignment check.
module mem_lane_align
  import mem_access_stage_pkg::*;
(
  input  logic [7:0]  aluop,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] reg2,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic [31:0] load_result,
  output logic        misaligned
);

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
    logic signed [7:0]  bs;
    logic signed [31:0] s;
    bs = b;
    s  = bs;
    return sgn ? s : {24'b0, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
    logic signed [15:0] hs;
    logic signed [31:0] s;
    hs = h;
    s  = hs;
    return sgn ? s : {16'b0, h};
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[31:24];
      2'd1:    byte_sel = rdata[23:16];
      2'd2:    byte_sel = rdata[15:8];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[15:0] : rdata[31:16];
  end

  always_comb begin
    sel         = '0;
    wdata       = '0;
    load_result = '0;
    misaligned  = 1'b0;
    case (aluop)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: begin
        sel         = 4'b1000 >> addr_lo;
        wdata       = {4{reg2[7:0]}};
        load_result = ext_byte(byte_sel, aluop == EXE_LB_OP);
      end
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: begin
        sel         = addr_lo[1] ? 4'b0011 : 4'b1100;
        wdata       = {2{reg2[15:0]}};
        load_result = ext_half(half_sel, aluop == EXE_LH_OP);
        misaligned  = addr_lo[0];
      end
      EXE_LW_OP, EXE_SW_OP: begin
        sel         = 4'b1111;
        wdata       = reg2;
        load_result = rdata;
        misaligned  = (addr_lo != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: pass-through for ALU results, req/ack bus FSM with stall for loads/stores.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq,
  output logic        addr_err,
  output logic        bus_err,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      rdata_q;
  logic             timeout_q;

  logic [3:0]  lane_sel;
  logic [31:0] lane_wdata;
  logic [31:0] load_result;
  logic        misaligned;
  logic        mem_op;
  logic        ld_op;
  logic        st_op;

  assign ld_op  = is_load(aluop_i);
  assign st_op  = is_store(aluop_i);
  assign mem_op = ld_op | st_op;

  // Extraction works on the captured word, since EX/MEM inputs stay frozen until DONE.
  mem_lane_align u_lane_align (
    .aluop       (aluop_i),
    .addr_lo     (mem_addr_i[1:0]),
    .reg2        (reg2_i),
    .rdata       (rdata_q),
    .sel         (lane_sel),
    .wdata       (lane_wdata),
    .load_result (load_result),
    .misaligned  (misaligned)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mem_op && !misaligned) begin
            state     <= ST_REQ;
            cnt       <= '0;
            timeout_q <= 1'b0;
          end
        end
        ST_REQ: begin
          if (dbus_ack) begin
            rdata_q <= dbus_rdata;
            state   <= ST_DONE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            state     <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Reset forces every output low in the same cycle, dropping an in-flight request.
  always_comb begin
    wd_o       = NOP_REG_ADDR;
    wreg_o     = WRITE_DISABLE;
    wdata_o    = ZERO_WORD;
    stallreq   = 1'b0;
    addr_err   = 1'b0;
    bus_err    = 1'b0;
    dbus_req   = 1'b0;
    dbus_we    = 1'b0;
    dbus_addr  = '0;
    dbus_sel   = '0;
    dbus_wdata = '0;
    if (rst != RST_ENABLE) begin
      wd_o    = wd_i;
      wdata_o = wdata_i;
      case (state)
        ST_IDLE: begin
          if (!mem_op)        wreg_o   = wreg_i;
          else if (misaligned) addr_err = 1'b1;
          else                stallreq = 1'b1;
        end
        ST_REQ: begin
          stallreq   = 1'b1;
          dbus_req   = 1'b1;
          dbus_we    = st_op;
          dbus_addr  = {mem_addr_i[31:2], 2'b00};
          dbus_sel   = lane_sel;
          dbus_wdata = lane_wdata;
        end
        ST_DONE: begin
          if (timeout_q) begin
            bus_err = 1'b1;
          end else if (ld_op) begin
            wreg_o  = wreg_i;
            wdata_o = load_result;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage against a behavioural lane/latency model.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq;
  logic        addr_err;
  logic        bus_err;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;

  mem_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .wd_i       (wd_i),
    .wreg_i     (wreg_i),
    .wdata_i    (wdata_i),
    .aluop_i    (aluop_i),
    .mem_addr_i (mem_addr_i),
    .reg2_i     (reg2_i),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .wdata_o    (wdata_o),
    .stallreq   (stallreq),
    .addr_err   (addr_err),
    .bus_err    (bus_err),
    .dbus_req   (dbus_req),
    .dbus_we    (dbus_we),
    .dbus_addr  (dbus_addr),
    .dbus_sel   (dbus_sel),
    .dbus_wdata (dbus_wdata),
    .dbus_ack   (dbus_ack),
    .dbus_rdata (dbus_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Access size in bytes; 0 means not a memory op.
  function automatic int m_size(input logic [7:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return 1;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return 2;
      EXE_LW_OP, EXE_SW_OP:             return 4;
      default:                          return 0;
    endcase
  endfunction

  function automatic logic m_is_load(input logic [7:0] op);
    return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
           (op == EXE_LHU_OP) || (op == EXE_LW_OP);
  endfunction

  function automatic logic [3:0] m_sel(input int sz, input int off);
    if (sz == 1) return 4'(1 << (3 - off));
    if (sz == 2) return (off < 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] r2);
    if (sz == 1) return (r2 & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (r2 & 32'hFFFF) * 32'h0001_0001;
    return r2;
  endfunction

  function automatic logic [31:0] m_load(input logic [7:0] op, input int off, input logic [31:0] rd);
    logic [31:0] v;
    v = rd;
    if (m_size(op) == 1) begin
      v = (rd >> (8 * (3 - off))) & 32'hFF;
      if (op == EXE_LB_OP && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (m_size(op) == 2) begin
      v = (rd >> (8 * (2 - off))) & 32'hFFFF;
      if (op == EXE_LH_OP && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // One instruction through the stage; ack_at = REQ cycle index of the ack, -1 for none.
  task automatic do_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] r2,
                       input logic [31:0] wdat, input logic [4:0] wd, input logic wreg,
                       input int ack_at, input logic [31:0] rd);
    int   sz;
    int   off;
    logic ld;
    logic st;
    logic mis;
    logic timed_out;
    sz  = m_size(op);
    off = int'(addr[1:0]);
    ld  = m_is_load(op);
    st  = (sz != 0) && !ld;
    mis = (sz == 2 && (off % 2) != 0) || (sz == 4 && off != 0);

    @(negedge clk);
    aluop_i    = op;
    mem_addr_i = addr;
    reg2_i     = r2;
    wdata_i    = wdat;
    wd_i       = wd;
    wreg_i     = wreg;
    dbus_ack   = 1'($urandom % 2);
    dbus_rdata = $urandom;
    #1;
    chk("idle_wd", 32'(wd_o), 32'(wd));
    chk("idle_req", 32'(dbus_req), 32'd0);
    if (sz == 0) begin
      chk("pass_wreg", 32'(wreg_o), 32'(wreg));
      chk("pass_wdata", wdata_o, wdat);
      chk("pass_stall", 32'(stallreq), 32'd0);
      chk("pass_aerr", 32'(addr_err), 32'd0);
      return;
    end
    if (mis) begin
      chk("mis_aerr", 32'(addr_err), 32'd1);
      chk("mis_stall", 32'(stallreq), 32'd0);
      chk("mis_wreg", 32'(wreg_o), 32'd0);
      return;
    end
    chk("idle_stall", 32'(stallreq), 32'd1);
    chk("idle_aerr", 32'(addr_err), 32'd0);

    timed_out = 1'b1;
    for (int k = 0; k < TIMEOUT; k++) begin
      @(negedge clk);
      dbus_ack   = (k == ack_at);
      dbus_rdata = (k == ack_at) ? rd : $urandom;
      #1;
      chk("req_req", 32'(dbus_req), 32'd1);
      chk("req_stall", 32'(stallreq), 32'd1);
      chk("req_we", 32'(dbus_we), 32'(st));
      chk("req_addr", dbus_addr, addr & 32'hFFFF_FFFC);
      chk("req_sel", 32'(dbus_sel), 32'(m_sel(sz, off)));
      chk("req_berr", 32'(bus_err), 32'd0);
      if (st) chk("req_wdata", dbus_wdata, m_wdata(sz, r2));
      if (k == ack_at) begin
        timed_out = 1'b0;
        break;
      end
    end

    @(negedge clk);
    dbus_ack   = 1'($urandom % 2);
    dbus_rdata = $urandom;
    #1;
    chk("done_stall", 32'(stallreq), 32'd0);
    chk("done_req", 32'(dbus_req), 32'd0);
    chk("done_berr", 32'(bus_err), 32'(timed_out));
    chk("done_aerr", 32'(addr_err), 32'd0);
    if (timed_out || st) begin
      chk("done_wreg0", 32'(wreg_o), 32'd0);
    end else begin
      chk("done_wreg", 32'(wreg_o), 32'(wreg));
      chk("done_wd", 32'(wd_o), 32'(wd));
      chk("done_load", wdata_o, m_load(op, off, rd));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ops [11];
    logic [7:0] op;
    int         ack_at;
    ops = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, 8'b0010_0101, 8'b0010_0100, 8'h00};

    rst        = 1'b1;
    aluop_i    = 8'b0010_0101;
    wd_i       = 5'd3;
    wreg_i     = 1'b1;
    wdata_i    = 32'h0000_1234;
    mem_addr_i = 32'h0000_0100;
    reg2_i     = 32'hFFFF_FFFF;
    dbus_ack   = 1'b1;
    dbus_rdata = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wd", 32'(wd_o), 32'd0);
    chk("rst_wreg", 32'(wreg_o), 32'd0);
    chk("rst_wdata", wdata_o, 32'd0);
    chk("rst_stall", 32'(stallreq), 32'd0);
    chk("rst_req", 32'(dbus_req), 32'd0);

    @(negedge clk);
    rst      = 1'b0;
    dbus_ack = 1'b0;
    #1;
    chk("post_rst_wdata", wdata_o, 32'h0000_1234);
    chk("post_rst_wreg", 32'(wreg_o), 32'd1);

    do_op(8'b0010_0101, 32'h0000_0040, 32'h0, 32'h0000_1234, 5'd3, 1'b1, -1, 32'h0);
    do_op(EXE_LB_OP,  32'h0000_0103, 32'h0, 32'h0, 5'd4, 1'b1, 0, 32'h0000_00F0);
    do_op(EXE_SH_OP,  32'h0000_0102, 32'hAAAA_5555, 32'h0, 5'd5, 1'b1, 0, 32'h0);
    do_op(EXE_LW_OP,  32'h0000_0101, 32'h0, 32'h0, 5'd6, 1'b1, 0, 32'h0);
    do_op(EXE_LW_OP,  32'h0000_0200, 32'h0, 32'h0, 5'd7, 1'b1, -1, 32'h1234_5678);
    do_op(EXE_LBU_OP, 32'h0000_0100, 32'h0, 32'h0, 5'd8, 1'b1, 2, 32'h8012_3456);

    // Reset during the second REQ cycle, then a late ack with a non-memory op.
    @(negedge clk);
    aluop_i    = EXE_LW_OP;
    mem_addr_i = 32'h0000_0300;
    wd_i       = 5'd9;
    wreg_i     = 1'b1;
    dbus_ack   = 1'b0;
    #1;
    chk("rreq_idle_stall", 32'(stallreq), 32'd1);
    @(negedge clk);
    #1;
    chk("rreq_req0", 32'(dbus_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rreq_req_drop", 32'(dbus_req), 32'd0);
    chk("rreq_stall", 32'(stallreq), 32'd0);
    chk("rreq_wd", 32'(wd_o), 32'd0);
    chk("rreq_wdata", wdata_o, 32'd0);
    chk("rreq_wreg", 32'(wreg_o), 32'd0);
    @(negedge clk);
    rst        = 1'b0;
    aluop_i    = 8'b0010_0101;
    wdata_i    = 32'h0000_CAFE;
    dbus_ack   = 1'b1;
    dbus_rdata = 32'h5555_AAAA;
    #1;
    chk("late_ack_stall", 32'(stallreq), 32'd0);
    chk("late_ack_req", 32'(dbus_req), 32'd0);
    chk("late_ack_wdata", wdata_o, 32'h0000_CAFE);
    chk("late_ack_wreg", 32'(wreg_o), 32'd1);
    @(negedge clk);
    dbus_ack = 1'b0;
    #1;
    chk("late_ack_idle", 32'(stallreq), 32'd0);

    for (int i = 0; i < 80; i++) begin
      op     = ops[$urandom_range(0, 10)];
      ack_at = (($urandom % 8) == 0) ? -1 : int'($urandom % 5);
      do_op(op, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom), ack_at, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
